// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants, FSM state codes and a small helper for the PWM duty meter.
package pwm_duty_meter_pkg;

    localparam int DUTY_W          = 7;
    localparam int PCT_SCALE       = 100;
    localparam int CNT_W_DEF       = 27;
    localparam int TIMEOUT_CYC_DEF = 2_500_000;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_DIVIDE   = 2'd2;

    // Duty reported when the input is lost: a stuck-high line reads as full duty.
    function automatic logic [DUTY_W-1:0] level_duty(input logic level);
        logic [DUTY_W-1:0] d;
        if (level) begin
            d = 7'd100;
        end else begin
            d = 7'd0;
        end
        return d;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// PWM input plus measurement results, bundled between the meter and its consumer.
interface pwm_duty_meter_if import pwm_duty_meter_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    logic              pwm_in;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              valid;
    logic              busy;
    logic              no_signal;

    modport master (output pwm_in,
                    input  duty, high_cnt, period_cnt, valid, busy, no_signal);
    modport slave  (input  pwm_in,
                    output duty, high_cnt, period_cnt, valid, busy, no_signal);
endinterface

// File: rtl/pwm_duty_meter_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The first bit is
// resolved in the start cycle itself, so done follows start by exactly N_W clocks.
module pwm_duty_meter_seq_divider #(
    parameter int N_W = 34,
    parameter int D_W = 27,
    parameter int Q_W = 7
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start_i,
    input  logic [N_W-1:0] num_i,
    input  logic [D_W-1:0] den_i,
    output logic [Q_W-1:0] quo_o,
    output logic           done_o
);
    localparam int             C_W        = $clog2(N_W);
    localparam logic [C_W-1:0] STEPS_LEFT = C_W'(N_W - 1);
    localparam logic [C_W-1:0] C_ONE      = C_W'(1);

    logic [N_W-1:0] num_q, num_d, src_num;
    logic [D_W-1:0] rem_q, rem_d, src_rem;
    logic [D_W-1:0] den_q, den_d, src_den;
    logic [D_W:0]   rem_t, rem_sub;
    logic [C_W-1:0] cnt_q, cnt_d;
    logic           run_q, run_d;
    logic           done_q, done_d;
    logic           q_bit;

    // One restoring step on either the fresh operands or the running state.
    always_comb begin
        if (start_i) begin
            src_num = num_i;
            src_rem = '0;
            src_den = den_i;
        end else begin
            src_num = num_q;
            src_rem = rem_q;
            src_den = den_q;
        end
        rem_t = {src_rem, src_num[N_W-1]};
        if (rem_t >= {1'b0, src_den}) begin
            rem_sub = rem_t - {1'b0, src_den};
            q_bit   = 1'b1;
        end else begin
            rem_sub = rem_t;
            q_bit   = 1'b0;
        end
    end

    // Step sequencing: load on start, count remaining steps, pulse done after the last.
    always_comb begin
        num_d  = num_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            num_d = {src_num[N_W-2:0], q_bit};
            rem_d = rem_sub[D_W-1:0];
            den_d = den_i;
            cnt_d = STEPS_LEFT;
            run_d = 1'b1;
        end else if (run_q) begin
            num_d = {src_num[N_W-2:0], q_bit};
            rem_d = rem_sub[D_W-1:0];
            cnt_d = cnt_q - C_ONE;
            if (cnt_q == C_ONE) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
                done_d = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Divider state registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quo_o  = num_q[Q_W-1:0];
    assign done_o = done_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM input between rising
// edges and reports duty in integer percent, with loss-of-signal detection.
module pwm_duty_meter import pwm_duty_meter_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    pwm_duty_meter_if.slave  bus
);
    localparam int               N_W         = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [N_W-1:0]   SCALE_N     = N_W'(PCT_SCALE);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [CNT_W-1:0]       cyc_cnt_q, cyc_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]       per_lat_q, per_lat_d, hi_lat_q, hi_lat_d;
    logic [1:0]             state_q, state_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic [CNT_W-1:0]       high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
    logic                   valid_q, valid_d, busy_q, busy_d, no_signal_q, no_signal_d;
    logic                   sync_s, r_edge_s, timeout_s, div_start_s, div_done_s;
    logic [N_W-1:0]         num_s;
    logic [DUTY_W-1:0]      div_quo_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign r_edge_s  = sync_s & ~dly_q;
    assign timeout_s = (cyc_cnt_q == TIMEOUT_VAL);
    assign num_s     = N_W'(hi_cnt_q) * SCALE_N;

    // Input synchronizer, edge-detect delay and the window counters.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        dly_d  = sync_s;
        if (r_edge_s) begin
            cyc_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            cyc_cnt_d = sat_inc(cyc_cnt_q);
            if (sync_s) begin
                hi_cnt_d = sat_inc(hi_cnt_q);
            end else begin
                hi_cnt_d = hi_cnt_q;
            end
        end
    end

    // Measurement FSM: arm on first edge, latch and divide on the next, watch for loss.
    always_comb begin
        state_d      = state_q;
        per_lat_d    = per_lat_q;
        hi_lat_d     = hi_lat_q;
        div_start_s  = 1'b0;
        duty_d       = duty_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        no_signal_d  = no_signal_q;
        valid_d      = 1'b0;
        case (state_q)
            ST_DISARMED: begin
                if (r_edge_s) begin
                    state_d = ST_ARMED;
                end else if (timeout_s) begin
                    duty_d       = level_duty(sync_s);
                    high_cnt_d   = '0;
                    period_cnt_d = '0;
                    no_signal_d  = 1'b1;
                    valid_d      = 1'b1;
                    state_d      = ST_DISARMED;
                end else begin
                    state_d = ST_DISARMED;
                end
            end
            ST_ARMED: begin
                if (r_edge_s) begin
                    per_lat_d   = cyc_cnt_q;
                    hi_lat_d    = hi_cnt_q;
                    div_start_s = 1'b1;
                    state_d     = ST_DIVIDE;
                end else if (timeout_s) begin
                    duty_d       = level_duty(sync_s);
                    high_cnt_d   = '0;
                    period_cnt_d = '0;
                    no_signal_d  = 1'b1;
                    valid_d      = 1'b1;
                    state_d      = ST_DISARMED;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_DIVIDE: begin
                // Edges arriving here only restart the counters; that window is dropped.
                if (div_done_s) begin
                    duty_d       = div_quo_s;
                    high_cnt_d   = hi_lat_q;
                    period_cnt_d = per_lat_q;
                    no_signal_d  = 1'b0;
                    valid_d      = 1'b1;
                    state_d      = ST_ARMED;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            default: begin
                state_d = ST_DISARMED;
            end
        endcase
        busy_d = (state_d == ST_DIVIDE);
    end

    // All state and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q       <= '0;
            dly_q        <= 1'b0;
            cyc_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            per_lat_q    <= '0;
            hi_lat_q     <= '0;
            state_q      <= ST_DISARMED;
            duty_q       <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            no_signal_q  <= 1'b1;
        end else begin
            sync_q       <= sync_d;
            dly_q        <= dly_d;
            cyc_cnt_q    <= cyc_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            per_lat_q    <= per_lat_d;
            hi_lat_q     <= hi_lat_d;
            state_q      <= state_d;
            duty_q       <= duty_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            no_signal_q  <= no_signal_d;
        end
    end

    pwm_duty_meter_seq_divider #(
        .N_W (N_W),
        .D_W (CNT_W),
        .Q_W (DUTY_W)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (div_start_s),
        .num_i   (num_s),
        .den_i   (cyc_cnt_q),
        .quo_o   (div_quo_s),
        .done_o  (div_done_s)
    );

    assign bus.duty       = duty_q;
    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
    assign bus.no_signal  = no_signal_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: waveforms with hand-computed duty results.
module tb_pwm_duty_meter;
    localparam int CNT_W   = 27;
    localparam int TIMEOUT = 12000;
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic reset_n;

    pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

    pwm_duty_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse and every busy run length.
    int n_valid = 0;
    int v_duty [64];
    int v_high [64];
    int v_per  [64];
    int v_ns   [64];
    int v_cyc  [64];
    int busy_run = 0, n_busy_runs = 0, n_busy_bad = 0;

    always @(negedge clk) begin
        if (bus.valid) begin
            if (n_valid < 64) begin
                v_duty[n_valid] <= int'(bus.duty);
                v_high[n_valid] <= int'(bus.high_cnt);
                v_per[n_valid]  <= int'(bus.period_cnt);
                v_ns[n_valid]   <= int'(bus.no_signal);
                v_cyc[n_valid]  <= cyc;
            end
            n_valid <= n_valid + 1;
        end
        if (!reset_n) begin
            busy_run <= 0;
        end else if (bus.busy) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            n_busy_runs <= n_busy_runs + 1;
            if (busy_run != DIV_LAT) n_busy_bad <= n_busy_bad + 1;
            busy_run <= 0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.pwm_in = v;
        tick(n);
    endtask

    task automatic pwm_periods(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, hi);
            drive(1'b0, per - hi);
        end
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        bus.pwm_in = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic check_rec(input string tag, input int idx, input int per,
                             input int hi, input int duty, input int ns);
        int k;
        k = (idx >= 0 && idx < 64) ? idx : 0;
        check_eq({tag, "_period"},    v_per[k],  per);
        check_eq({tag, "_high"},      v_high[k], hi);
        check_eq({tag, "_duty"},      v_duty[k], duty);
        check_eq({tag, "_no_signal"}, v_ns[k],   ns);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_duty"},      bus.duty,       0);
        check_eq({tag, "_high"},      bus.high_cnt,   0);
        check_eq({tag, "_period"},    bus.period_cnt, 0);
        check_eq({tag, "_valid"},     bus.valid,      0);
        check_eq({tag, "_busy"},      bus.busy,       0);
        check_eq({tag, "_no_signal"}, bus.no_signal,  1);
    endtask

    initial begin
        int base, rise, bbase;
        bit seen;

        reset_n    = 1'b0;
        bus.pwm_in = 1'b0;
        @(posedge clk);
        #1;
        tick(2);
        check_reset_vals("rst");
        reset_n = 1'b1;

        // Period 10, high 3: rise 2 latches, rises inside the divide are dropped.
        base = n_valid;
        drive(1'b1, 3);
        drive(1'b0, 7);
        rise = cyc;
        pwm_periods(10, 3, 11);
        drive(1'b0, 50);
        check_eq("t1_valid_count", n_valid - base, 3);
        check_rec("t1_first", base, 10, 3, 30, 0);
        check_rec("t1_last", base + 2, 10, 3, 30, 0);
        check_eq("t1_latency", v_cyc[base] - rise, 37);
        check_eq("t1_hold_duty", bus.duty, 30);
        check_eq("t1_hold_ns", bus.no_signal, 0);

        // Loop-back style 50 % at period 10000.
        apply_reset();
        base = n_valid;
        pwm_periods(10000, 5000, 3);
        drive(1'b0, 50);
        check_eq("t2_valid_count", n_valid - base, 2);
        check_rec("t2_last", base + 1, 10000, 5000, 50, 0);

        // Floor rounding and near-full duty.
        apply_reset();
        base = n_valid;
        pwm_periods(3, 1, 20);
        drive(1'b0, 50);
        check_eq("t3a_valid_count", n_valid - base, 2);
        check_rec("t3a", base + 1, 3, 1, 33, 0);
        apply_reset();
        base = n_valid;
        pwm_periods(7, 6, 5);
        drive(1'b0, 50);
        check_eq("t3b_valid_count", n_valid - base, 1);
        check_rec("t3b", base, 7, 6, 85, 0);
        apply_reset();
        base = n_valid;
        pwm_periods(200, 199, 3);
        drive(1'b0, 50);
        check_eq("t3c_valid_count", n_valid - base, 2);
        check_rec("t3c", base + 1, 200, 199, 99, 0);

        // Stuck high -> timeout, then restart needs two rises.
        apply_reset();
        base = n_valid;
        pwm_periods(10, 5, 2);
        drive(1'b1, TIMEOUT + 100);
        check_eq("t4_valid_count", n_valid - base, 2);
        check_rec("t4_meas", base, 10, 5, 50, 0);
        check_rec("t4_timeout", base + 1, 0, 0, 100, 1);
        check_eq("t4_live_ns", bus.no_signal, 1);
        check_eq("t4_live_duty", bus.duty, 100);
        drive(1'b0, 5);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check_eq("t4_first_rise_silent", n_valid - base, 2);
        drive(1'b1, 5);
        drive(1'b0, 50);
        check_eq("t4_restart_count", n_valid - base, 3);
        check_rec("t4_restart", base + 2, 10, 5, 50, 0);

        // Reset pulse in the middle of a division.
        apply_reset();
        base = n_valid;
        pwm_periods(10, 3, 6);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        check_eq("t5_busy_seen", seen, 1);
        check_eq("t5_pre_count", n_valid - base, 1);
        check_eq("t5_pre_duty", bus.duty, 30);
        tick(3);
        reset_n = 1'b0;
        tick(1);
        check_reset_vals("t5_rst");
        reset_n = 1'b1;
        tick(60);
        check_eq("t5_no_late_valid", n_valid - base, 1);
        check_eq("t5_busy_idle", bus.busy, 0);

        // Period 20, shorter than the divide: every second window dropped.
        apply_reset();
        base  = n_valid;
        bbase = n_busy_runs;
        pwm_periods(20, 7, 8);
        drive(1'b0, 50);
        check_eq("t6_valid_count", n_valid - base, 4);
        check_rec("t6_first", base, 20, 7, 35, 0);
        check_rec("t6_last", base + 3, 20, 7, 35, 0);
        check_eq("t6_busy_runs", n_busy_runs - bbase, 4);
        check_eq("busy_len_bad", n_busy_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
